// File: rtl/tile_color_pipeline.sv
// ============================================================================
//  Module      : tile_color_pipeline
//  Description : Two-stage pipelined pixel colour resolver sitting between the
//                sprite/tile logic and the VGA output. Per pixel the colour is
//                chosen, in priority order, from: playfield window (outside is
//                black), sprite layers (index 0 highest priority), optional
//                grid overlay, and a writable 24-bit palette indexed by
//                blockID. Palette writes are buffered in a single-entry slot
//                and only land in the palette while vblank is high.
//
//  Ports       : Clk, Reset            clock, synchronous active-high reset
//                pix_valid             pixel inputs valid this cycle
//                DrawX, DrawY          pixel coordinates (10 bit each)
//                blockID               tile type at pixel (ID_W bits)
//                sprite_hit            per-layer hit flags (NUM_SPRITES bits)
//                sprite_rgb            per-layer colours, layer i at [24*i+:24]
//                vblank                vertical blanking flag
//                pal_wr_valid/ready    palette write handshake
//                pal_wr_addr/data      palette write entry and {R,G,B} value
//                out_valid             VGA_* carry a valid pixel
//                VGA_R, VGA_G, VGA_B   resolved colour, 2 cycles after input
//
//  Config      : define GRID_OVERLAY_EN to draw GRID_RGB grid lines every
//                TILE_SIZE pixels inside the window; undefined removes the
//                grid term entirely.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_color_pipeline #(
    parameter int          NUM_SPRITES = 2,
    parameter int          ID_W        = 3,
    parameter int          TILE_SIZE   = 40,
    parameter int          X_MIN       = 120,
    parameter int          X_MAX       = 520,
    parameter int          Y_MIN       = 40,
    parameter int          Y_MAX       = 440,
    parameter logic [23:0] GRID_RGB    = 24'hFF8000
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      pix_valid,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [ID_W-1:0]           blockID,
    input  logic [NUM_SPRITES-1:0]    sprite_hit,
    input  logic [24*NUM_SPRITES-1:0] sprite_rgb,
    input  logic                      vblank,
    input  logic                      pal_wr_valid,
    output logic                      pal_wr_ready,
    input  logic [ID_W-1:0]           pal_wr_addr,
    input  logic [23:0]               pal_wr_data,
    output logic                      out_valid,
    output logic [7:0]                VGA_R,
    output logic [7:0]                VGA_G,
    output logic [7:0]                VGA_B
);

    localparam int         c_pal_depth = 2 ** ID_W;
    localparam logic [9:0] c_x_min     = 10'(X_MIN);
    localparam logic [9:0] c_x_max     = 10'(X_MAX);
    localparam logic [9:0] c_y_min     = 10'(Y_MIN);
    localparam logic [9:0] c_y_max     = 10'(Y_MAX);

    // Power-on palette contents; anything beyond the first eight is black.
    function automatic logic [23:0] f_pal_default(input int idx);
        case (idx)
            0:       f_pal_default = 24'h3F007F;
            1:       f_pal_default = 24'h5E3C21;
            2:       f_pal_default = 24'h9E4D0E;
            3:       f_pal_default = 24'hFFB700;
            4:       f_pal_default = 24'h22FF00;
            5:       f_pal_default = 24'h107500;
            6:       f_pal_default = 24'h22571A;
            7:       f_pal_default = 24'h75A66D;
            default: f_pal_default = 24'h000000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: window test, sprite priority encode, grid test
    // ------------------------------------------------------------------
    logic            w_win;
    logic            w_any_hit;
    logic [23:0]     w_sprite_rgb;

    assign w_win = (DrawX >= c_x_min) && (DrawX < c_x_max) &&
                   (DrawY >= c_y_min) && (DrawY < c_y_max);

    // Scan from the lowest-priority layer upward so the lowest hit index
    // is the last (winning) assignment.
    always_comb begin
        w_any_hit    = 1'b0;
        w_sprite_rgb = 24'h000000;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (sprite_hit[i]) begin
                w_any_hit    = 1'b1;
                w_sprite_rgb = sprite_rgb[24*i +: 24];
            end
        end
    end

    logic            r_s1_valid;
    logic            r_s1_win;
    logic            r_s1_hit;
    logic [23:0]     r_s1_sprite_rgb;
    logic [ID_W-1:0] r_s1_id;
    logic [6:0]      r_s1_xdiv;

`ifdef GRID_OVERLAY_EN
    localparam logic [9:0] c_tile = 10'(TILE_SIZE);
    logic w_grid;
    logic r_s1_grid;

    assign w_grid = ((DrawX % c_tile) == 10'd0) || ((DrawY % c_tile) == 10'd0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_grid <= 1'b0;
        end else begin
            r_s1_grid <= w_grid;
        end
    end
`else
    // Grid configuration has no effect in this build.
    logic w_unused_grid_cfg;
    assign w_unused_grid_cfg = (^GRID_RGB) ^ (TILE_SIZE != 0);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid      <= 1'b0;
            r_s1_win        <= 1'b0;
            r_s1_hit        <= 1'b0;
            r_s1_sprite_rgb <= 24'h000000;
            r_s1_id         <= '0;
            r_s1_xdiv       <= 7'd0;
        end else begin
            r_s1_valid      <= pix_valid;
            r_s1_win        <= w_win;
            r_s1_hit        <= w_any_hit;
            r_s1_sprite_rgb <= w_sprite_rgb;
            r_s1_id         <= blockID;
            r_s1_xdiv       <= DrawX[9:3];
        end
    end

    // ------------------------------------------------------------------
    // Palette and single-entry write buffer
    // ------------------------------------------------------------------
    logic [23:0]     r_pal [c_pal_depth];
    logic            r_pend;
    logic [ID_W-1:0] r_pend_addr;
    logic [23:0]     r_pend_data;

    // The slot is free whenever nothing is pending; a commit clears the
    // pending flag so ready returns on the cycle after the commit.
    assign pal_wr_ready = !r_pend;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= 24'h000000;
            for (int i = 0; i < c_pal_depth; i++) begin
                r_pal[i] <= f_pal_default(i);
            end
        end else begin
            if (r_pend && vblank) begin
                r_pal[r_pend_addr] <= r_pend_data;
                r_pend             <= 1'b0;
            end else if (pal_wr_valid && !r_pend) begin
                r_pend      <= 1'b1;
                r_pend_addr <= pal_wr_addr;
                r_pend_data <= pal_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: final colour select
    // ------------------------------------------------------------------
    logic [23:0] w_pal_rgb;
    logic [7:0]  w_xdiv_ext;
    logic [7:0]  w_blue_adj;
    logic [23:0] w_base_rgb;
    logic [23:0] w_color;

    assign w_pal_rgb  = r_pal[r_s1_id];
    assign w_xdiv_ext = {1'b0, r_s1_xdiv};

    // Entry 0 fades its blue channel across the screen; clamp at zero
    // instead of wrapping.
    assign w_blue_adj = (w_pal_rgb[7:0] >= w_xdiv_ext) ? (w_pal_rgb[7:0] - w_xdiv_ext)
                                                       : 8'h00;
    assign w_base_rgb = (r_s1_id == '0) ? {w_pal_rgb[23:8], w_blue_adj} : w_pal_rgb;

    always_comb begin
        w_color = w_base_rgb;
        if (!r_s1_win) begin
            w_color = 24'h000000;
        end else if (r_s1_hit) begin
            w_color = r_s1_sprite_rgb;
        end
`ifdef GRID_OVERLAY_EN
        else if (r_s1_grid) begin
            w_color = GRID_RGB;
        end
`endif
    end

    logic        r_out_valid;
    logic [23:0] r_out_rgb;

    // Colour holds its last value across invalid pixels.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_out_rgb   <= 24'h000000;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_rgb <= w_color;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign VGA_R     = r_out_rgb[23:16];
    assign VGA_G     = r_out_rgb[15:8];
    assign VGA_B     = r_out_rgb[7:0];

endmodule

`default_nettype wire

// File: tb/tb_tile_color_pipeline.sv
// ============================================================================
//  Module      : tb_tile_color_pipeline
//  Description : Self-checking bench for tile_color_pipeline. A behavioural
//                reference model resolves each pixel from the colour rules
//                and tracks the palette and its write buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_color_pipeline;

    localparam int NS = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_valid;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [2:0]  blockID;
    logic [1:0]  sprite_hit;
    logic [47:0] sprite_rgb;
    logic        vblank;
    logic        pal_wr_valid;
    logic        pal_wr_ready;
    logic [2:0]  pal_wr_addr;
    logic [23:0] pal_wr_data;
    logic        out_valid;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;

    always #5 Clk = ~Clk;

    tile_color_pipeline dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .pix_valid    (pix_valid),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blockID      (blockID),
        .sprite_hit   (sprite_hit),
        .sprite_rgb   (sprite_rgb),
        .vblank       (vblank),
        .pal_wr_valid (pal_wr_valid),
        .pal_wr_ready (pal_wr_ready),
        .pal_wr_addr  (pal_wr_addr),
        .pal_wr_data  (pal_wr_data),
        .out_valid    (out_valid),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit          v;
        int          x;
        int          y;
        int          id;
        logic [1:0]  hit;
        logic [47:0] rgb;
    } pix_t;

    logic [23:0] m_pal [8];
    bit          m_pend;
    int          m_addr;
    logic [23:0] m_data;
    pix_t        m_prev;
    bit          m_exp_valid;
    logic [23:0] m_exp_rgb;

    function automatic logic [23:0] default_pal(input int i);
        logic [23:0] t [8];
        t = '{24'h3F007F, 24'h5E3C21, 24'h9E4D0E, 24'hFFB700,
              24'h22FF00, 24'h107500, 24'h22571A, 24'h75A66D};
        return t[i];
    endfunction

    function automatic logic [23:0] resolve(input pix_t p);
        logic [23:0] c;
        int          b;
        if (p.x < 120 || p.x >= 520 || p.y < 40 || p.y >= 440) return 24'h000000;
        for (int i = 0; i < NS; i++) begin
            if (p.hit[i]) return p.rgb[24*i +: 24];
        end
`ifdef GRID_OVERLAY_EN
        if ((p.x % 40) == 0 || (p.y % 40) == 0) return 24'hFF8000;
`endif
        c = m_pal[p.id];
        if (p.id == 0) begin
            b = int'(c[7:0]) - p.x / 8;
            if (b < 0) b = 0;
            c[7:0] = 8'(b);
        end
        return c;
    endfunction

    // Advance the model by one clock edge using the inputs the bench drove.
    task automatic model_edge();
        pix_t cur;
        cur.v   = pix_valid;
        cur.x   = int'(DrawX);
        cur.y   = int'(DrawY);
        cur.id  = int'(blockID);
        cur.hit = sprite_hit;
        cur.rgb = sprite_rgb;
        if (Reset) begin
            for (int i = 0; i < 8; i++) m_pal[i] = default_pal(i);
            m_pend      = 0;
            m_prev.v    = 0;
            m_exp_valid = 0;
            m_exp_rgb   = 24'h000000;
        end else begin
            m_exp_valid = m_prev.v;
            if (m_prev.v) m_exp_rgb = resolve(m_prev);
            if (m_pend && vblank) begin
                m_pal[m_addr] = m_data;
                m_pend        = 0;
            end else if (pal_wr_valid && !m_pend) begin
                m_pend = 1;
                m_addr = int'(pal_wr_addr);
                m_data = pal_wr_data;
            end
            m_prev = cur;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_exp_valid});
        check_eq("rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, m_exp_rgb});
        check_eq("ready", {31'd0, pal_wr_ready}, {31'd0, !m_pend});
    endtask

    task automatic pix(input int x, input int y, input int id, input logic [1:0] hit,
                       input logic [23:0] r0, input logic [23:0] r1,
                       input logic [23:0] exp, input string tag);
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        blockID    = 3'(id);
        sprite_hit = hit;
        sprite_rgb = {r1, r0};
        pix_valid  = 1'b1;
        step();
        pix_valid  = 1'b0;
        step();
        check_eq(tag, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp});
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic pal_write(input int addr, input logic [23:0] data);
        pal_wr_addr  = 3'(addr);
        pal_wr_data  = data;
        pal_wr_valid = 1'b1;
        step();
        pal_wr_valid = 1'b0;
    endtask

    logic [23:0] grid_exp;

    initial begin
        Reset        = 1'b1;
        pix_valid    = 1'b0;
        DrawX        = '0;
        DrawY        = '0;
        blockID      = '0;
        sprite_hit   = '0;
        sprite_rgb   = '0;
        vblank       = 1'b0;
        pal_wr_valid = 1'b0;
        pal_wr_addr  = '0;
        pal_wr_data  = '0;
        m_pend       = 0;
        m_prev.v     = 0;
        repeat (3) step();
        Reset = 1'b0;
        step();
        check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check_eq("reset_ready", {31'd0, pal_wr_ready}, 32'd1);

        // Directed colour resolution
        pix(200, 100, 1, 2'b00, 24'h0, 24'h0, 24'h5E3C21, "pal1");
        pix(100, 100, 1, 2'b01, 24'hFFFFFF, 24'h0, 24'h000000, "left_oow_sprite");
        pix(520, 439, 1, 2'b00, 24'h0, 24'h0, 24'h000000, "x_max_edge");
        pix(200, 100, 1, 2'b11, 24'hFFFFFF, 24'h03FCEC, 24'hFFFFFF, "sprite_prio");
        pix(200, 100, 1, 2'b10, 24'hFFFFFF, 24'h03FCEC, 24'h03FCEC, "sprite1");
        pix(200, 100, 0, 2'b00, 24'h0, 24'h0, 24'h3F0066, "blue_fade");
        pix(519, 439, 4, 2'b00, 24'h0, 24'h0, 24'h22FF00, "last_inside");
`ifdef GRID_OVERLAY_EN
        grid_exp = 24'hFF8000;
`else
        grid_exp = 24'h9E4D0E;
`endif
        pix(240, 101, 2, 2'b00, 24'h0, 24'h0, grid_exp, "grid");
        pix(240, 80, 2, 2'b01, 24'hAABBCC, 24'h0, 24'hAABBCC, "sprite_over_grid");

        // Buffered write held off until vblank
        vblank = 1'b0;
        pal_write(3, 24'h123456);
        DrawX = 10'd200; DrawY = 10'd100; blockID = 3'd3; sprite_hit = 2'b00;
        pix_valid = 1'b1;
        repeat (100) step();
        check_eq("pend_ready_low", {31'd0, pal_wr_ready}, 32'd0);
        check_eq("pend_old_colour", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h00FFB700);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        check_eq("ready_after_commit", {31'd0, pal_wr_ready}, 32'd1);
        step();
        step();
        check_eq("new_colour", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h00123456);
        pix_valid = 1'b0;
        step();

        // Reset while a write is pending discards it
        pal_write(3, 24'hABCDEF);
        repeat (3) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        vblank = 1'b1;
        repeat (2) step();
        vblank = 1'b0;
        pix(200, 100, 3, 2'b00, 24'h0, 24'h0, 24'hFFB700, "reset_drop");

        // Write accepted during vblank: ready low exactly one cycle
        vblank = 1'b1;
        pal_write(0, 24'h3F0010);
        check_eq("ready_low_1cyc", {31'd0, pal_wr_ready}, 32'd0);
        step();
        check_eq("ready_back", {31'd0, pal_wr_ready}, 32'd1);
        vblank = 1'b0;
        pix(519, 100, 0, 2'b00, 24'h0, 24'h0, 24'h3F0000, "blue_saturate");

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            pix_valid    = ($urandom_range(0, 3) != 0);
            DrawX        = ($urandom_range(0, 2) == 0) ? 10'(40 * $urandom_range(2, 13))
                                                       : 10'($urandom_range(80, 560));
            DrawY        = ($urandom_range(0, 2) == 0) ? 10'(40 * $urandom_range(0, 11))
                                                       : 10'($urandom_range(0, 479));
            blockID      = 3'($urandom_range(0, 7));
            sprite_hit   = 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            sprite_rgb   = {24'($urandom), 24'($urandom)};
            vblank       = ($urandom_range(0, 4) == 0);
            pal_wr_valid = ($urandom_range(0, 5) == 0);
            pal_wr_addr  = 3'($urandom_range(0, 7));
            pal_wr_data  = 24'($urandom);
            Reset        = ($urandom_range(0, 199) == 0);
            step();
        end
        Reset = 1'b0;
        pix_valid = 1'b0;
        pal_wr_valid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
